input_capture_pio: RTL



---
 rtl/input_capture_pio.sv | 88 ++++++++
 1 files changed

// File: rtl/input_capture_pio.sv
// input_capture_pio: synchronised, debounced input PIO with edge capture, IRQ and an Avalon-MM register slave
module input_capture_pio #(
    parameter int WIDTH           = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [WIDTH-1:0] in_export,
    input  logic [1:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             irq
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [CW-1:0]    cnt [WIDTH];
    logic [WIDTH-1:0] sync, stable, stable_d, rise, fall, set_bits, edge_q, mask, clr;
    logic [1:0]       cfg;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    assign sync         = sync_q[SYNC_STAGES-1];
    assign rise         = stable & ~stable_d;
    assign fall         = ~stable & stable_d;
    assign set_bits     = (rise & {WIDTH{cfg[0]}}) | (fall & {WIDTH{cfg[1]}});
    assign clr          = (avs_write && avs_address == 2'd1) ? avs_writedata[WIDTH-1:0] : '0;
    assign unused_wdata = ^avs_writedata;

    // metastability chain: each bit walks SYNC_STAGES flops before use
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= in_export;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    // per-bit debounce: a new level must persist DEBOUNCE_CYCLES cycles before it is accepted
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            stable <= '0;
            for (int k = 0; k < WIDTH; k++) cnt[k] <= '0;
        end else begin
            for (int k = 0; k < WIDTH; k++) begin
                if (sync[k] == stable[k]) begin
                    cnt[k] <= '0;
                end else if (cnt[k] == CNT_MAX) begin
                    stable[k] <= sync[k];
                    cnt[k]    <= '0;
                end else begin
                    cnt[k] <= cnt[k] + 1'b1;
                end
            end
        end
    end

    // read mux; unimplemented bits are zero-extended away
    always_comb begin
        rd_mux = avs_address == 2'd0 ? 32'(stable) :
                 avs_address == 2'd1 ? 32'(edge_q) :
                 avs_address == 2'd2 ? 32'(mask)   : 32'(cfg);
    end

    // capture, W1C (set dominates), control registers, registered irq and read data
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            stable_d     <= '0;
            edge_q       <= '0;
            mask         <= '0;
            cfg          <= 2'b01;
            irq          <= 1'b0;
            avs_readdata <= '0;
        end else begin
            stable_d <= stable;
            edge_q   <= (edge_q & ~clr) | set_bits;
            irq      <= |(edge_q & mask);
            if (avs_write && avs_address == 2'd2) mask <= avs_writedata[WIDTH-1:0];
            if (avs_write && avs_address == 2'd3) cfg <= avs_writedata[1:0];
            if (avs_read) avs_readdata <= rd_mux;
        end
    end
endmodule
